// File: rtl/loot_score_keeper_pkg.sv
// Shared game definitions: loot-type codes (also used by the loot map),
// the level-flow state encoding and the datapath widths.
package loot_score_keeper_pkg;

  localparam int SCORE_W = 16;
  localparam int TIME_W  = 7;
  localparam int LOOT_W  = 8;
  localparam int LEVEL_W = 3;
  localparam int TYPE_W  = 3;

  localparam logic [TYPE_W-1:0] LOOT_NONE = 3'd0;
  localparam logic [TYPE_W-1:0] LOOT_GOLD = 3'd1;
  localparam logic [TYPE_W-1:0] LOOT_ROCK = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_SETTLE,
    ST_PLAY,
    ST_JUDGE
  } state_e;

endpackage

// File: rtl/loot_score_keeper_sec_timer.sv
// Frame-to-seconds divider: counts start_of_frame pulses while enabled and
// raises sec_tick_o in the same cycle as every FRAMES_PER_SEC-th pulse.
module loot_score_keeper_sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  input  logic frame_i,
  output logic sec_tick_o
);

  localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAMES_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    wrap  = en_i && frame_i && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (load_i)               cnt_d = '0;
    else if (en_i && frame_i) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sec_tick_o = wrap;

endmodule

// File: rtl/loot_score_keeper.sv
// Per-level game flow for the loot game: kicks the loot map, keeps score,
// counts down the level timer and decides pass, fail or win.
module loot_score_keeper
  import loot_score_keeper_pkg::*;
#(
  parameter int GOLD_POINTS    = 50,
  parameter int ROCK_POINTS    = 10,
  parameter int TARGET_BASE    = 100,
  parameter int TARGET_STEP    = 100,
  parameter int LEVEL_SECONDS  = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int MAX_LEVEL      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_start,
  input  logic               start_of_frame,
  input  logic [TYPE_W-1:0]  caugth_loot_type,
  input  logic               claw_home,
  input  logic [LOOT_W-1:0]  total_amount,
  output logic               start_level,
  output logic [LEVEL_W-1:0] level_num,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] target,
  output logic [TIME_W-1:0]  time_left,
  output logic [LOOT_W-1:0]  loot_remaining,
  output logic               playing,
  output logic               game_over,
  output logic               game_won
);

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   score_q, score_d, target_q, target_d, pts;
  logic [SCORE_W:0]     sum;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [LOOT_W-1:0]    loot_q, loot_d;
  logic [TYPE_W-1:0]    pending_q, pending_d;
  logic                 over_q, over_d, won_q, won_d;
  logic                 catch_ev, time_up, board_clear, sec_tick, pass, last_level;

  assign catch_ev    = caugth_loot_type != LOOT_NONE;
  assign time_up     = time_q == '0;
  assign board_clear = (loot_q == '0) && (pending_q == LOOT_NONE);
  assign pass        = score_q >= target_q;
  assign last_level  = level_q == LEVEL_W'(MAX_LEVEL);

  loot_score_keeper_sec_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_sec_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == ST_LOAD),
    .en_i       ((state_q == ST_PLAY) && !time_up && !board_clear),
    .frame_i    (start_of_frame),
    .sec_tick_o (sec_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (game_start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_KICK;
      ST_KICK:   state_d = ST_SETTLE;
      ST_SETTLE: if (start_of_frame) state_d = ST_PLAY;
      ST_PLAY:   if (time_up || board_clear) state_d = ST_JUDGE;
      ST_JUDGE:  state_d = (pass && !last_level) ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_level = state_q == ST_KICK;
    playing     = state_q == ST_PLAY;
  end

  always_comb begin
    level_d   = level_q;
    score_d   = score_q;
    target_d  = target_q;
    time_d    = time_q;
    loot_d    = loot_q;
    pending_d = pending_q;
    over_d    = over_q;
    won_d     = won_q;
    pts       = '0;
    sum       = '0;
    case (state_q)
      ST_IDLE: if (game_start) begin
        level_d = LEVEL_W'(1);
        score_d = '0;
        over_d  = 1'b0;
        won_d   = 1'b0;
      end
      ST_LOAD: begin
        target_d  = SCORE_W'(TARGET_BASE) + SCORE_W'(TARGET_STEP) * SCORE_W'(level_q - 3'd1);
        time_d    = TIME_W'(LEVEL_SECONDS);
        pending_d = LOOT_NONE;
      end
      ST_SETTLE: if (start_of_frame) loot_d = total_amount;
      ST_PLAY: begin
        // Leaving PLAY this cycle: on expiry the pending catch is dropped unpaid.
        if (time_up) begin
          pending_d = LOOT_NONE;
        end else if (!board_clear) begin
          case (pending_q)
            LOOT_GOLD: pts = SCORE_W'(GOLD_POINTS);
            LOOT_ROCK: pts = SCORE_W'(ROCK_POINTS);
            default:   pts = '0;
          endcase
          if (catch_ev || claw_home) begin
            sum     = {1'b0, score_q} + {1'b0, pts};
            score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
          end
          if (catch_ev) begin
            loot_d    = (loot_q == '0) ? '0 : loot_q - 1'b1;
            pending_d = caugth_loot_type;
          end else if (claw_home) begin
            pending_d = LOOT_NONE;
          end
          if (sec_tick) time_d = time_q - 1'b1;
        end
      end
      ST_JUDGE: begin
        if (!pass)           over_d  = 1'b1;
        else if (last_level) won_d   = 1'b1;
        else                 level_d = level_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= '0;
      score_q   <= '0;
      target_q  <= '0;
      time_q    <= '0;
      loot_q    <= '0;
      pending_q <= LOOT_NONE;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      score_q   <= score_d;
      target_q  <= target_d;
      time_q    <= time_d;
      loot_q    <= loot_d;
      pending_q <= pending_d;
      over_q    <= over_d;
      won_q     <= won_d;
    end
  end

  assign level_num      = level_q;
  assign score          = score_q;
  assign target         = target_q;
  assign time_left      = time_q;
  assign loot_remaining = loot_q;
  assign game_over      = over_q;
  assign game_won       = won_q;

endmodule

// File: tb/tb_loot_score_keeper.sv
// Directed bench for loot_score_keeper: a row table for scoring in PLAY plus
// hand-written sequences for start-up timing, expiry, reset, win and saturation.
module tb_loot_score_keeper;
  import loot_score_keeper_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        game_start = 1'b0;
  logic        start_of_frame = 1'b0;
  logic [2:0]  caugth_loot_type = 3'd0;
  logic        claw_home = 1'b0;
  logic [7:0]  total_amount = 8'd0;
  logic        start_level;
  logic [2:0]  level_num;
  logic [15:0] score, target;
  logic [6:0]  time_left;
  logic [7:0]  loot_remaining;
  logic        playing, game_over, game_won;

  int n_cmp = 0;
  int n_fail = 0;

  loot_score_keeper dut (
    .clk              (clk),
    .reset            (reset),
    .game_start       (game_start),
    .start_of_frame   (start_of_frame),
    .caugth_loot_type (caugth_loot_type),
    .claw_home        (claw_home),
    .total_amount     (total_amount),
    .start_level      (start_level),
    .level_num        (level_num),
    .score            (score),
    .target           (target),
    .time_left        (time_left),
    .loot_remaining   (loot_remaining),
    .playing          (playing),
    .game_over        (game_over),
    .game_won         (game_won)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  typ;
    logic        claw;
    logic [15:0] exp_score;
    logic [7:0]  exp_loot;
    logic [2:0]  exp_pend;
  } row_t;

  row_t rows [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      caugth_loot_type = rows[i].typ;
      claw_home        = rows[i].claw;
      tick();
      caugth_loot_type = 3'd0;
      claw_home        = 1'b0;
      check($sformatf("row%0d score", i), 32'(score), 32'(rows[i].exp_score));
      check($sformatf("row%0d loot", i), 32'(loot_remaining), 32'(rows[i].exp_loot));
      check($sformatf("row%0d pending", i), 32'(dut.pending_q), 32'(rows[i].exp_pend));
    end
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  // Waits (bounded) for the start_level pulse, then settles into PLAY.
  task automatic enter_level(input logic [7:0] amount);
    bit seen = 0;
    total_amount = amount;
    for (int i = 0; i < 20; i++) begin
      if (start_level) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("start_level seen", 32'(seen), 32'd1);
    tick();
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    check("enter playing", 32'(playing), 32'd1);
    check("enter loot", 32'(loot_remaining), 32'(amount));
  endtask

  // 3600 frames with no catches; ends in the cycle where time_left reads 0.
  task automatic expire();
    for (int i = 0; i < 3600; i++) begin
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      if (i == 59) check("time after 60 frames", 32'(time_left), 32'd59);
      if (i != 3599) tick();
    end
    check("time expired", 32'(time_left), 32'd0);
    check("still playing at 0", 32'(playing), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " start_level"}, 32'(start_level), 32'd0);
    check({tag, " level"}, 32'(level_num), 32'd0);
    check({tag, " score"}, 32'(score), 32'd0);
    check({tag, " target"}, 32'(target), 32'd0);
    check({tag, " time"}, 32'(time_left), 32'd0);
    check({tag, " loot"}, 32'(loot_remaining), 32'd0);
    check({tag, " playing"}, 32'(playing), 32'd0);
    check({tag, " over"}, 32'(game_over), 32'd0);
    check({tag, " won"}, 32'(game_won), 32'd0);
    check({tag, " state"}, 32'(dut.state_q), 32'(ST_IDLE));
    check({tag, " pending"}, 32'(dut.pending_q), 32'd0);
  endtask

  initial begin
    // Level 1 (starts at score 0, loot 40), then level 2 (score 100, loot 30).
    rows[0] = '{3'd1, 1'b0, 16'd0,   8'd39, 3'd1};
    rows[1] = '{3'd0, 1'b1, 16'd50,  8'd39, 3'd0};
    rows[2] = '{3'd0, 1'b0, 16'd50,  8'd39, 3'd0};
    rows[3] = '{3'd1, 1'b0, 16'd50,  8'd38, 3'd1};
    rows[4] = '{3'd0, 1'b1, 16'd100, 8'd38, 3'd0};
    rows[5] = '{3'd2, 1'b0, 16'd100, 8'd37, 3'd2};
    rows[6] = '{3'd1, 1'b0, 16'd100, 8'd29, 3'd1};
    rows[7] = '{3'd2, 1'b1, 16'd150, 8'd28, 3'd2};
    rows[8] = '{3'd0, 1'b1, 16'd160, 8'd28, 3'd0};

    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Start-up: pulse is in cycle 3 and lasts one cycle.
    total_amount = 8'd40;
    pulse_start();
    check("cyc2 start_level", 32'(start_level), 32'd0);
    check("cyc2 level", 32'(level_num), 32'd1);
    tick();
    check("cyc3 start_level", 32'(start_level), 32'd1);
    check("cyc3 target", 32'(target), 32'd100);
    tick();
    check("cyc4 start_level", 32'(start_level), 32'd0);
    tick();
    check("settle waits", 32'(playing), 32'd0);
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    check("play loot", 32'(loot_remaining), 32'd40);
    check("play time", 32'(time_left), 32'd60);
    check("play target", 32'(target), 32'd100);
    check("play flag", 32'(playing), 32'd1);

    run_rows(0, 5);

    // Expire with a rock pending: level passes at 100 and the rock is dropped.
    expire();
    tick();
    check("judge state", 32'(dut.state_q), 32'(ST_JUDGE));
    tick();
    check("L2 level", 32'(level_num), 32'd2);
    tick();
    check("L2 target", 32'(target), 32'd200);
    check("L2 score no rock", 32'(score), 32'd100);
    check("L2 kick", 32'(start_level), 32'd1);
    enter_level(8'd30);
    run_rows(6, 8);

    // Reset in PLAY overrides a simultaneous game_start.
    reset      = 1'b1;
    game_start = 1'b1;
    tick();
    reset      = 1'b0;
    game_start = 1'b0;
    check_all_zero("midplay reset");

    // Zero-score expiry ends the game; later catches are ignored.
    total_amount = 8'd5;
    pulse_start();
    enter_level(8'd5);
    expire();
    tick();
    check("fail judge state", 32'(dut.state_q), 32'(ST_JUDGE));
    check("over not yet", 32'(game_over), 32'd0);
    tick();
    check("over set", 32'(game_over), 32'd1);
    check("over idle", 32'(dut.state_q), 32'(ST_IDLE));
    caugth_loot_type = 3'd1;
    tick();
    caugth_loot_type = 3'd0;
    check("idle catch loot", 32'(loot_remaining), 32'd5);
    check("idle catch score", 32'(score), 32'd0);

    // Win run; level 1 drives the score into saturation via back-to-back golds.
    pulse_start();
    check("over cleared", 32'(game_over), 32'd0);
    enter_level(8'd3);
    caugth_loot_type = 3'd1;
    for (int k = 0; k < 1311; k++) tick();
    check("score before sat", 32'(score), 32'd65500);
    check("loot floor", 32'(loot_remaining), 32'd0);
    tick();
    caugth_loot_type = 3'd0;
    check("score saturated", 32'(score), 32'hFFFF);
    claw_home = 1'b1;
    tick();
    claw_home = 1'b0;
    check("score stays sat", 32'(score), 32'hFFFF);
    for (int lv = 2; lv <= 4; lv++) begin
      enter_level(8'd3);
      if (lv == 2) begin
        pulse_start();
        check("start ignored level", 32'(level_num), 32'd2);
        check("start ignored play", 32'(playing), 32'd1);
      end
      for (int j = 0; j < 3; j++) begin
        caugth_loot_type = 3'd2;
        tick();
        caugth_loot_type = 3'd0;
        claw_home = 1'b1;
        tick();
        claw_home = 1'b0;
      end
    end
    for (int i = 0; i < 10 && !game_won; i++) tick();
    check("game won", 32'(game_won), 32'd1);
    check("won level", 32'(level_num), 32'd4);
    check("won no over", 32'(game_over), 32'd0);
    check("won score", 32'(score), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
